// File: rtl/shift_add_mul_if.sv
// Operand/result bundle for the shift-and-add multiplier.
// master drives start/a/b and observes busy/done/z; slave is the multiplier side.
interface shift_add_mul_if #(
   parameter int WIDTH = 16
);
   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   z;

   modport master (
      output start, a, b,
      input  busy, done, z
   );

   modport slave (
      input  start, a, b,
      output busy, done, z
   );
endinterface

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier, one partial product per cycle.
// Ports: clk, rst (async, active-high), bus (slave: start/a/b in, busy/done/z out).
module shift_add_mul #(
   parameter int WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   shift_add_mul_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [WIDTH-1:0]     r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_z;
   logic [CW-1:0]        r_cnt;

   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic                 w_last;
   logic                 w_busy;
   logic                 w_done;

   // Partial product for this iteration: multiplicand weighted by bit index.
   assign w_addend   = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
   assign w_acc_next = r_mplier[0] ? (r_acc + w_addend) : r_acc;
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_next = r_state;
      w_busy = 1'b1;
      w_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.start) w_next = S_RUN;
         end
         S_RUN: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_z      <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand  <= bus.a;
                  r_mplier <= bus.b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_RUN: begin
               r_acc    <= w_acc_next;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CW'(1);
               // Result lands together with the final partial product.
               if (w_last) r_z <= w_acc_next;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.z    = r_z;

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  multiplicand, unsigned; this is the operand bus driven by io_serdes.
REQ-006 Port: b  input  WIDTH  multiplier, unsigned; this is the operand bus driven by io_serdes.
REQ-007 Port: busy  output  1  high whenever the state is not IDLE.
REQ-008 Port: done  output  1  one-cycle pulse marking a newly valid z.
REQ-009 Port: z  output  2*WIDTH  product register; holds its value until the next completion.

Function
REQ-010 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 IDLE with start=1 at an edge SHALL:
- capture a into a multiplicand register and b into a multiplier register;
- clear the accumulator and the iteration counter;
- move to RUN.
REQ-012 IDLE with start=0 SHALL stay in IDLE, with all registers unchanged.
REQ-013 Each RUN edge SHALL:
- if the multiplier register LSB is 1, add the multiplicand register, shifted left by the counter value, into the 2*WIDTH accumulator;
- shift the multiplier register right by 1;
- increment the counter.
REQ-014 The accumulator SHALL be 2*WIDTH bits; the sum never overflows, so no carry-out is kept.
REQ-015 After exactly WIDTH RUN iterations, the last RUN edge SHALL:
- load z with the final accumulator value, including that last iteration's contribution;
- move to DONE.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE on the next edge, regardless of start.
REQ-017 done SHALL be 1 only while in DONE.
REQ-018 Latency is fixed and data-independent, with no early termination on zero operands:
- start sampled at edge 0;
- z updated and done high after edge WIDTH;
- busy low again after edge WIDTH+1.
REQ-019 start SHALL be ignored in RUN and DONE; there is no queuing.
REQ-020 start held high continuously SHALL produce back-to-back operations, one every WIDTH+2 cycles, with a new capture at each IDLE edge.
REQ-021 Changes on a or b after the capture edge SHALL NOT affect the result in progress.
REQ-022 z SHALL change only on the completion edge of REQ-015 or on reset.

Reset
REQ-023 While rst=1, the block SHALL asynchronously force:
- state=IDLE, busy=0, done=0, z=0;
- multiplicand, multiplier, accumulator and counter to 0.
REQ-024 rst asserted during RUN or DONE SHALL abort the operation; no done pulse and no z update may follow.
REQ-025 After rst deasserts, the first edge with start=1 SHALL begin a normal operation.

Verification
REQ-026 WIDTH=16, a=3, b=5, one-cycle start:
- busy=1 one edge later;
- done=1 for exactly one cycle, 16 cycles after the start edge;
- z=0x0000000F.
REQ-027 WIDTH=16, a=0xFFFF, b=0xFFFF:
- z=0xFFFE0001 with done;
- then a=0, b=0x1234 gives z=0x00000000 with identical latency.
REQ-028 a=0x00FF, b=0x0100 captured, then a and b randomised every cycle during RUN:
- z=0x0000FF00.
REQ-029 start tied high for three operations (a=2,b=3; a=7,b=9; a=0x8000,b=2):
- done pulses spaced 18 cycles apart;
- z=6, then 63, then 0x00010000.
REQ-030 Reset mid-operation:
- complete a=4, b=4 to z=16;
- start a=6, b=7, then assert rst at RUN iteration 5, asynchronously between edges;
- busy, done and z go to 0 immediately;
- no done pulse follows;
- next start with a=6, b=7 gives z=42.
REQ-031 Random regression, WIDTH=8 and WIDTH=16, at least 1000 operations each: every z SHALL equal a*b computed at full 2*WIDTH width.
